// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 multicycle controller: state encoding,
// opcode patterns, ALU control codes and the instruction classes seen by the FSM.
package legv8_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC_R = 4'd2,
        ST_WB_R   = 4'd3,
        ST_ADDR   = 4'd4,
        ST_MEM_RD = 4'd5,
        ST_MEM_WR = 4'd6,
        ST_WB_LD  = 4'd7,
        ST_CBZ_EX = 4'd8,
        ST_FAULT  = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_LD  = 3'd1,
        CLS_ST  = 3'd2,
        CLS_CBZ = 3'd3,
        CLS_ILL = 3'd4
    } op_class_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    // CBZ is a wildcard pattern: the low three opcode bits belong to the
    // branch offset, so they are masked out before comparing.
    localparam logic [10:0] OP_CBZ      = 11'b10110100000;
    localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    function automatic logic op_is_cbz(input logic [10:0] op);
        return (op & OP_CBZ_MASK) == OP_CBZ;
    endfunction

    function automatic logic is_req_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/legv8_op_class.sv
// Combinational opcode classifier: maps instr[31:21] onto the instruction class
// that steers the control FSM out of DECODE and ADDR.
module legv8_op_class
    import legv8_pkg::*;
(
    input  logic [10:0] op,
    output op_class_t   op_class
);

    // Everything that is not an exact LDUR/STUR/R-format match or a CBZ
    // pattern match is illegal.
    always_comb begin
        op_class = CLS_ILL;
        if (op_is_cbz(op)) begin
            op_class = CLS_CBZ;
        end else begin
            case (op)
                OP_LDUR:                        op_class = CLS_LD;
                OP_STUR:                        op_class = CLS_ST;
                OP_ADD, OP_SUB, OP_AND, OP_ORR: op_class = CLS_R;
                default:                        op_class = CLS_ILL;
            endcase
        end
    end

endmodule

// File: rtl/legv8_mc_ctrl.sv
// Multicycle control FSM for the LEGv8 datapath with a variable-latency memory
// handshake and a per-access watchdog that drops the controller into FAULT.
module legv8_mc_ctrl
    import legv8_pkg::*;
#(
    parameter int TO_CYCLES = 16,
    parameter int CW        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] op,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg2loc,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        fault,
    output logic [3:0]  state_o
);

    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    op_class_t     op_class;
    logic [CW-1:0] to_cnt;
    logic [CW-1:0] to_cnt_next;
    logic          waiting;
    logic          timeout;

    legv8_op_class u_op_class (
        .op       (op),
        .op_class (op_class)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_FETCH;
            to_cnt <= '0;
        end else begin
            state  <= state_next;
            to_cnt <= to_cnt_next;
        end
    end

    // The counter holds the number of unanswered request cycles so far; the
    // cycle that would make it TO_CYCLES is the last one a request may live,
    // and an ack in that same cycle still completes normally.
    always_comb begin
        waiting     = is_req_state(state) && !mem_ack;
        timeout     = waiting && (to_cnt == TO_LAST);
        to_cnt_next = waiting ? to_cnt + CW'(1) : '0;
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        fault      = 1'b0;
        state_o    = state;

        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end else if (timeout) begin
                    state_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                reg2loc = (op_class == CLS_ST) || (op_class == CLS_CBZ);
                case (op_class)
                    CLS_LD, CLS_ST: state_next = ST_ADDR;
                    CLS_CBZ:        state_next = ST_CBZ_EX;
                    CLS_R:          state_next = ST_EXEC_R;
                    default:        state_next = ST_FAULT;
                endcase
            end
            ST_EXEC_R: begin
                alu_op     = ALU_FUNCT;
                state_next = ST_WB_R;
            end
            ST_WB_R: begin
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_ADDR: begin
                alu_src    = 1'b1;
                alu_op     = ALU_ADD;
                state_next = (op_class == CLS_ST) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ack) begin
                    state_next = ST_WB_LD;
                end else if (timeout) begin
                    state_next = ST_FAULT;
                end
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                reg2loc = 1'b1;
                if (mem_ack) begin
                    state_next = ST_FETCH;
                end else if (timeout) begin
                    state_next = ST_FAULT;
                end
            end
            ST_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = ST_FETCH;
            end
            ST_CBZ_EX: begin
                reg2loc    = 1'b1;
                alu_op     = ALU_PASSB;
                pc_write   = zero;
                pc_src     = zero;
                state_next = ST_FETCH;
            end
            ST_FAULT: begin
                fault      = 1'b1;
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase

        // While reset is held every output is forced quiet, whatever state
        // the register happens to contain.
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            reg2loc    = 1'b0;
            alu_src    = 1'b0;
            alu_op     = ALU_ADD;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            fault      = 1'b0;
            state_o    = 4'd0;
        end
    end

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// Randomized bench for legv8_mc_ctrl: an instruction-level planner queues the
// expected per-cycle outputs and a negedge monitor compares them against the DUT.
module tb_legv8_mc_ctrl;

    localparam int TO_CYCLES = 16;
    localparam bit N = 1'b0;
    localparam bit Y = 1'b1;

    localparam int C_R   = 0;
    localparam int C_LD  = 1;
    localparam int C_ST  = 2;
    localparam int C_CBZ = 3;
    localparam int C_ILL = 4;

    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;

    typedef logic [16:0] vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] op;
    logic        zero;
    logic        mem_ack;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src;
    logic        reg2loc, alu_src, reg_write, mem_to_reg, fault;
    logic [1:0]  alu_op;
    logic [3:0]  state_o;

    vec_t expq[$];
    vec_t actual;
    vec_t popped;
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle_no   = 0;
    bit   ack_always = 1'b0;

    always #5 clk = ~clk;

    legv8_mc_ctrl #(.TO_CYCLES(TO_CYCLES), .CW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg2loc    (reg2loc),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .fault      (fault),
        .state_o    (state_o)
    );

    assign actual = {state_o, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                     reg2loc, alu_src, alu_op, reg_write, mem_to_reg, fault};

    function automatic vec_t mk_vec(input logic [3:0] st, input logic req, input logic we,
                                    input logic io, input logic irw, input logic pcw,
                                    input logic pcs, input logic r2l, input logic asrc,
                                    input logic [1:0] aop, input logic rw, input logic m2r,
                                    input logic flt);
        return {st, req, we, io, irw, pcw, pcs, r2l, asrc, aop, rw, m2r, flt};
    endfunction

    function automatic int legal_class(input logic [10:0] o);
        if (o[10:3] == 8'b10110100) return C_CBZ;
        if (o == T_LDUR) return C_LD;
        if (o == T_STUR) return C_ST;
        if (o == T_ADD || o == T_SUB || o == T_AND || o == T_ORR) return C_R;
        return C_ILL;
    endfunction

    function automatic logic [10:0] gen_op(input int cls);
        logic [10:0] o;
        logic [2:0]  low;
        case (cls)
            C_LD:  o = T_LDUR;
            C_ST:  o = T_STUR;
            C_CBZ: begin
                low = 3'($urandom);
                o   = {8'b10110100, low};
            end
            C_R: begin
                case ($urandom_range(0, 3))
                    0:       o = T_ADD;
                    1:       o = T_SUB;
                    2:       o = T_AND;
                    default: o = T_ORR;
                endcase
            end
            default: begin
                // Illegal ops are either fully random or one bit away from a legal one.
                do begin
                    if ($urandom_range(0, 1) == 0) begin
                        o = 11'($urandom);
                    end else begin
                        o = gen_op(int'($urandom_range(0, 3)));
                        o[$urandom_range(0, 10)] ^= 1'b1;
                    end
                end while (legal_class(o) != C_ILL);
            end
        endcase
        return o;
    endfunction

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 14) return int'($urandom_range(0, 3));
        if (r < 17) return TO_CYCLES - 1;
        if (r == 17) return TO_CYCLES;
        if (r == 18) return int'($urandom_range(4, TO_CYCLES - 2));
        return TO_CYCLES + 5;
    endfunction

    function automatic logic noise_ack();
        return ack_always ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic checkOutput(input vec_t e);
        cycle_no++;
        compared++;
        if (actual !== e) begin
            mismatched++;
            $display("[TB] FAIL cycle %0d outputs: actual st=%0d bits=%b, required st=%0d bits=%b",
                     cycle_no, actual[16:13], actual[12:0], e[16:13], e[12:0]);
        end
    endtask

    // Monitor: one expected record per clock cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            popped = expq.pop_front();
            checkOutput(popped);
        end
    end

    task automatic applyStimulus(input logic rst, input logic ack, input logic z,
                                 input logic [10:0] o, input vec_t e);
        reset   = rst;
        mem_ack = ack;
        zero    = z;
        op      = o;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        applyStimulus(1'b1, rnd_bit(), rnd_bit(), 11'($urandom), '0);
    endtask

    task automatic fault_hold();
        int n;
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, rnd_bit(), rnd_bit(), 11'($urandom),
                          mk_vec(4'd15, N, N, N, N, N, N, N, N, 2'b00, N, N, Y));
        reset_cycle();
    endtask

    // kind 0 = instruction fetch, 1 = data read, 2 = data write; a request
    // lives at most TO_CYCLES cycles, the ack arriving after `delay` waits.
    task automatic mem_phase(input int kind, input int delay, input logic [10:0] iop, output bit ok);
        logic        ack;
        logic [10:0] o;
        vec_t        e;
        ok = 1'b0;
        for (int i = 0; i < TO_CYCLES; i++) begin
            ack = (i == delay);
            o   = (kind == 0) ? 11'($urandom) : iop;
            case (kind)
                0:       e = mk_vec(4'd0, Y, N, N, ack, ack, N, N, N, 2'b00, N, N, N);
                1:       e = mk_vec(4'd5, Y, N, Y, N, N, N, N, N, 2'b00, N, N, N);
                default: e = mk_vec(4'd6, Y, Y, Y, N, N, N, Y, N, 2'b00, N, N, N);
            endcase
            applyStimulus(1'b0, ack, rnd_bit(), o, e);
            if (ack) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_instr(input int cls, input logic [10:0] iop, input int fetch_delay,
                             input int mem_delay, input int zsel);
        bit   ok;
        logic z;
        logic r2l;
        mem_phase(0, fetch_delay, iop, ok);
        if (!ok) begin
            fault_hold();
            return;
        end
        r2l = (cls == C_ST) || (cls == C_CBZ);
        applyStimulus(1'b0, noise_ack(), rnd_bit(), iop,
                      mk_vec(4'd1, N, N, N, N, N, N, r2l, N, 2'b00, N, N, N));
        case (cls)
            C_R: begin
                applyStimulus(1'b0, noise_ack(), rnd_bit(), iop,
                              mk_vec(4'd2, N, N, N, N, N, N, N, N, 2'b10, N, N, N));
                applyStimulus(1'b0, noise_ack(), rnd_bit(), iop,
                              mk_vec(4'd3, N, N, N, N, N, N, N, N, 2'b00, Y, N, N));
            end
            C_LD, C_ST: begin
                applyStimulus(1'b0, noise_ack(), rnd_bit(), iop,
                              mk_vec(4'd4, N, N, N, N, N, N, N, Y, 2'b00, N, N, N));
                mem_phase((cls == C_LD) ? 1 : 2, mem_delay, iop, ok);
                if (!ok)
                    fault_hold();
                else if (cls == C_LD)
                    applyStimulus(1'b0, noise_ack(), rnd_bit(), iop,
                                  mk_vec(4'd7, N, N, N, N, N, N, N, N, 2'b00, Y, Y, N));
            end
            C_CBZ: begin
                z = (zsel < 0) ? rnd_bit() : zsel[0];
                applyStimulus(1'b0, noise_ack(), z, iop,
                              mk_vec(4'd8, N, N, N, N, z, z, Y, N, 2'b01, N, N, N));
            end
            default: fault_hold();
        endcase
    endtask

    initial begin
        int cls;
        reset   = 1'b1;
        mem_ack = 1'b0;
        zero    = 1'b0;
        op      = '0;
        @(posedge clk);
        #1;

        // Reset for two cycles with a permanently asserted ack, then one ADD.
        ack_always = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, T_ADD, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, T_ADD, '0);
        run_instr(C_R, T_ADD, 0, 0, -1);
        ack_always = 1'b0;

        run_instr(C_LD, T_LDUR, 0, 3, -1);
        run_instr(C_CBZ, 11'b10110100101, 0, 0, 1);
        run_instr(C_CBZ, 11'b10110100101, 0, 0, 0);
        run_instr(C_ST, T_STUR, 0, TO_CYCLES + 3, -1);
        run_instr(C_ST, T_STUR, 0, TO_CYCLES - 1, -1);
        run_instr(C_ILL, 11'b00000000000, 0, 0, -1);

        // Reset lands in MEM_RD together with an ack: the load must vanish.
        run_instr(C_R, T_SUB, 0, 0, -1);
        applyStimulus(1'b0, 1'b1, 1'b0, 11'($urandom),
                      mk_vec(4'd0, Y, N, N, Y, Y, N, N, N, 2'b00, N, N, N));
        applyStimulus(1'b0, 1'b0, 1'b0, T_LDUR,
                      mk_vec(4'd1, N, N, N, N, N, N, N, N, 2'b00, N, N, N));
        applyStimulus(1'b0, 1'b0, 1'b0, T_LDUR,
                      mk_vec(4'd4, N, N, N, N, N, N, N, Y, 2'b00, N, N, N));
        applyStimulus(1'b0, 1'b0, 1'b0, T_LDUR,
                      mk_vec(4'd5, Y, N, Y, N, N, N, N, N, 2'b00, N, N, N));
        applyStimulus(1'b1, 1'b1, 1'b0, T_LDUR, '0);
        run_instr(C_R, T_ORR, TO_CYCLES - 1, 0, -1);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 24) == 0)
                reset_cycle();
            cls = int'($urandom_range(0, 9));
            if (cls > C_ILL) cls = cls - 5;
            run_instr(cls, gen_op(cls), pick_delay(), pick_delay(), -1);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        mismatched++;
        $display("[TB] FAIL watchdog: actual run still going, required completion before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/legv8_mc_ctrl.md
Name: legv8_mc_ctrl

Overview:
- Multicycle control FSM for the LEGv8 datapath (register file, ALU, sign extender, unified instruction/data memory).
- Sequences fetch, decode, execute, memory and writeback steps for LDUR, STUR, CBZ and R-format ADD/SUB/AND/ORR.
- Handshakes with a variable-latency memory and enforces a watchdog timeout on every memory access.
- Sits between the IR opcode field and all datapath enables/muxes; replaces the single-cycle combinational decoder.

Parameters:
- TO_CYCLES, 16, maximum cycles a memory request may wait for mem_ack before entering FAULT (valid range 2..255).
- CW, 8, width of the timeout counter; must satisfy 2**CW > TO_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  11  instr[31:21] from the IR.
- zero  in  1  ALU zero flag (CBZ test on Rt).
- mem_ack  in  1  memory completed the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write request (valid with mem_req).
- iord  out  1  0 = address from PC, 1 = address from ALUOut.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = PC + (sext << 2).
- reg2loc  out  1  1 = read port 2 addresses Rt (STUR/CBZ).
- alu_src  out  1  1 = ALU B operand from the sign extender.
- alu_op  out  2  00 add, 01 pass-B/zero test, 10 funct decode.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  1 = writeback from MDR.
- fault  out  1  sticky: illegal opcode or memory timeout.
- state_o  out  4  current state encoding (debug).

Behaviour:
- Reset: synchronous, active-high. When reset is sampled high, state <= FETCH, timeout counter <= 0 and fault <= 0. Reset overrides every other event, including mem_ack in the same cycle; an in-flight memory request is abandoned.
- Outputs are Moore (decoded from state only), except ir_write and pc_write in FETCH, which are mem_ack-qualified.
- All outputs are 0 while reset is asserted.
- States and transitions:
  - FETCH: mem_req=1, iord=0. On mem_ack: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise stay.
  - DECODE: reg2loc = (op is STUR or CBZ). Next state by op:
    - LDUR/STUR -> ADDR
    - CBZ (10110100xxx) -> CBZ_EX
    - ADD 10001011000 / SUB 11001011000 / AND 10001010000 / ORR 10101010000 -> EXEC_R
    - any other op -> FAULT.
  - EXEC_R: alu_op=10, alu_src=0 -> WB_R.
  - WB_R: reg_write=1, mem_to_reg=0 -> FETCH.
  - ADDR: alu_src=1, alu_op=00 -> MEM_RD (LDUR) or MEM_WR (STUR).
  - MEM_RD: mem_req=1, iord=1, mem_we=0. On mem_ack -> WB_LD. Otherwise stay.
  - MEM_WR: mem_req=1, iord=1, mem_we=1, reg2loc=1. On mem_ack -> FETCH. Otherwise stay.
  - WB_LD: reg_write=1, mem_to_reg=1 -> FETCH.
  - CBZ_EX: reg2loc=1, alu_op=01. If zero: pc_write=1, pc_src=1. Always -> FETCH.
  - FAULT: all enables 0, fault=1. Terminal until reset.
- Request holding: mem_req, mem_we and iord stay constant from the first request cycle until the ack cycle inclusive. Back-to-back requests are allowed, e.g. MEM_WR ack -> FETCH asserts mem_req the next cycle.
- Timeout counter:
  - Clears on entry to FETCH/MEM_RD/MEM_WR and on every mem_ack.
  - Increments each cycle mem_req=1 && !mem_ack.
  - When it reaches TO_CYCLES with no ack -> FAULT; no ir_write/pc_write/reg_write occurs.
  - mem_ack arriving in the same cycle as count==TO_CYCLES wins: normal transition, no fault.
- mem_ack while mem_req=0 is ignored.
- CBZ opcode matching ignores op[2:0]. LDUR/STUR and R-format opcodes require exact 11-bit matches.
- Latency (zero-wait memory, ack in the first request cycle):
  - R-format: 4 cycles
  - LDUR: 5 cycles
  - STUR: 4 cycles
  - CBZ: 3 cycles
- Each memory wait cycle adds 1 cycle.
- state_o encoding:
  - FETCH 0, DECODE 1, EXEC_R 2, WB_R 3, ADDR 4, MEM_RD 5, MEM_WR 6, WB_LD 7, CBZ_EX 8, FAULT 15.

Decomposition:
- Package legv8_pkg:
  - state_t enum, with the encoding above.
  - Opcode localparams OP_LDUR, OP_STUR, OP_CBZ (wildcard pattern), OP_ADD, OP_SUB, OP_AND, OP_ORR.
  - ALU_ADD, ALU_PASSB, ALU_FUNCT constants for alu_op.
- Sub-module legv8_op_class: combinational op -> class {R, LD, ST, CBZ, ILL}. Reused by the FSM and by the verification scoreboard.
- Timeout counter stays inline in legv8_mc_ctrl.

Test Plan:
- Reset held 2 cycles, then released, with mem_ack=1 every cycle, op=10001011000 (ADD) -> state sequence 0,1,2,3,0; reg_write=1 only in state 3; pc_write=1 only in the FETCH ack cycle.
- LDUR (11111000010), mem_ack delayed 3 cycles in MEM_RD:
  - MEM_RD held for 4 cycles with mem_req=1, iord=1, mem_we=0 constant.
  - Then WB_LD with reg_write=1, mem_to_reg=1.
  - Total 8 cycles.
- CBZ (10110100101):
  - With zero=1: CBZ_EX asserts pc_write=1, pc_src=1.
  - Repeat with zero=0: pc_write=0.
  - Both return to FETCH next cycle.
- STUR (11111000000), mem_ack never asserted, TO_CYCLES=16:
  - Exactly 16 cycles of mem_req in MEM_WR, then state_o=15 and fault=1.
  - No reg_write at any point.
  - Repeat with ack arriving exactly at count 16 -> FETCH, fault=0.
- Illegal op 00000000000 -> DECODE then FAULT with fault=1 sticky. Reset asserted one cycle -> state 0, fault=0.
- Reset in MEM_RD with mem_ack=1 the same cycle -> state 0 next cycle, no reg_write, counter cleared.
